// File: rtl/fifo_param_thresh_pkg.sv
// Shared transaction-layer definitions: state-machine encodings seen by every TL block.
package fifo_param_thresh_pkg;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

endpackage : fifo_param_thresh_pkg

// File: rtl/fifo_param_thresh_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module sdp_ram_sclk #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array, no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its last value when not reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sdp_ram_sclk

// File: rtl/fifo_param_thresh.sv
// Parametrised synchronous FIFO with run-time almost-full/empty thresholds and sticky error flags.
module fifo_param_thresh
    import fifo_param_thresh_pkg::*;
#(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned ADDR_W    = 3,
    parameter bit          DROP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W:0]   umbral_superior,
    input  logic [ADDR_W:0]   umbral_inferior,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_thr_hi;
    logic [CNT_W-1:0]  r_thr_lo;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_soft_clr;
    logic w_full;
    logic w_empty;
    logic w_zero_drop;
    logic w_wr_en;
    logic w_rd_en;

    // Request qualification: full/empty come straight from the occupancy counter.
    always_comb begin
        w_soft_clr  = (state == ST_RESET);
        w_full      = (r_count == DEPTH_C);
        w_empty     = (r_count == '0);
        w_zero_drop = DROP_ZERO && (data_in == '0);
        w_wr_en     = push & ~w_full  & ~w_zero_drop & ~w_soft_clr;
        w_rd_en     = pop  & ~w_empty & ~w_soft_clr;
    end

    // Pointers, occupancy, thresholds, read-valid and sticky error flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_thr_hi    <= '0;
            r_thr_lo    <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_soft_clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_thr_hi    <= '0;
            r_thr_lo    <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                r_thr_hi <= umbral_superior;
                r_thr_lo <= umbral_inferior;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_valid <= w_rd_en;
            if (push & w_full & ~w_zero_drop) begin
                r_overflow <= 1'b1;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    sdp_ram_sclk #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_L),
        .i_clr   (w_soft_clr),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    // Status flags decode combinationally; RESET forces the quiescent pattern.
    always_comb begin
        full         = ~w_soft_clr & w_full;
        empty        =  w_soft_clr | w_empty;
        almost_full  = ~w_soft_clr & (r_count >= r_thr_hi);
        almost_empty = ~w_soft_clr & (r_count <= r_thr_lo);
    end

    assign count     = r_count;
    assign valid_out = r_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : fifo_param_thresh

// File: tb/tb_fifo_param_thresh.sv
// Directed bench for fifo_param_thresh: reset, thresholds, full/empty edges, wrap and DROP_ZERO.
module tb_fifo_param_thresh;

    localparam logic [3:0] S_RESET  = 4'b0001;
    localparam logic [3:0] S_INIT   = 4'b0010;
    localparam logic [3:0] S_IDLE   = 4'b0100;
    localparam logic [3:0] S_ACTIVE = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] state;
    logic       push;
    logic       pop;
    logic [9:0] data_in;
    logic [3:0] umbral_superior;
    logic [3:0] umbral_inferior;

    logic [9:0] data_out,  dz_data_out;
    logic       valid_out, dz_valid_out;
    logic [3:0] count,     dz_count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic       dz_full, dz_empty, dz_almost_full, dz_almost_empty, dz_overflow, dz_underflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_w;

    always #5 clk = ~clk;

    fifo_param_thresh #(.DATA_W(10), .ADDR_W(3), .DROP_ZERO(1'b0)) u_dut (
        .clk (clk), .reset_L (reset_L), .state (state), .push (push), .pop (pop),
        .data_in (data_in), .umbral_superior (umbral_superior), .umbral_inferior (umbral_inferior),
        .data_out (data_out), .valid_out (valid_out), .count (count), .full (full), .empty (empty),
        .almost_full (almost_full), .almost_empty (almost_empty),
        .overflow (overflow), .underflow (underflow)
    );

    fifo_param_thresh #(.DATA_W(10), .ADDR_W(3), .DROP_ZERO(1'b1)) u_dz (
        .clk (clk), .reset_L (reset_L), .state (state), .push (push), .pop (pop),
        .data_in (data_in), .umbral_superior (umbral_superior), .umbral_inferior (umbral_inferior),
        .data_out (dz_data_out), .valid_out (dz_valid_out), .count (dz_count), .full (dz_full),
        .empty (dz_empty), .almost_full (dz_almost_full), .almost_empty (dz_almost_empty),
        .overflow (dz_overflow), .underflow (dz_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b0; state = S_IDLE; push = 1'b0; pop = 1'b0; data_in = '0;
        umbral_superior = '0; umbral_inferior = '0;
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        chk("rst_afull_thr0", 32'(almost_full), 32'd1);
        chk("rst_aempty_thr0", 32'(almost_empty), 32'd1);

        // Soft RESET state forces the quiescent flag pattern.
        reset_L = 1'b1; state = S_RESET;
        tick();
        chk("soft_afull", 32'(almost_full), 32'd0);
        chk("soft_aempty", 32'(almost_empty), 32'd0);
        chk("soft_empty", 32'(empty), 32'd1);

        // Latch thresholds upper=6, lower=1.
        state = S_INIT; umbral_superior = 4'd6; umbral_inferior = 4'd1;
        tick();
        state = S_ACTIVE; umbral_superior = 4'd0; umbral_inferior = 4'd0;
        chk("init_aempty", 32'(almost_empty), 32'd1);
        chk("init_afull", 32'(almost_full), 32'd0);

        // Fill to DEPTH, watching the threshold flags move.
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = 10'(10'h100 + i);
            exp_q.push_back(data_in);
            tick();
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
            chk("fill_aempty", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);

        // Push while full is rejected and flagged.
        data_in = 10'h3FF;
        tick();
        push = 1'b0;
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // Push+pop while full: pop wins, push rejected, oldest word comes out.
        push = 1'b1; pop = 1'b1; data_in = 10'h2AA;
        tick();
        push = 1'b0;
        exp_w = exp_q.pop_front();
        chk("fullpp_dout", 32'(data_out), 32'h101);
        chk("fullpp_q", 32'(data_out), 32'(exp_w));
        chk("fullpp_valid", 32'(valid_out), 32'd1);
        chk("fullpp_count", 32'(count), 32'd7);

        // Drain down to 4.
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            chk("drain4_dout", 32'(data_out), 32'(exp_w));
        end
        chk("drain4_count", 32'(count), 32'd4);

        // Ten cycles of simultaneous push+pop at count=4.
        push = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 10'(10'h200 + k);
            exp_q.push_back(data_in);
            tick();
            exp_w = exp_q.pop_front();
            chk("pp_count", 32'(count), 32'd4);
            chk("pp_valid", 32'(valid_out), 32'd1);
            chk("pp_dout", 32'(data_out), 32'(exp_w));
        end
        push = 1'b0;
        chk("pp_last", 32'(data_out), 32'h205);

        // Drain the remaining four words.
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_w = exp_q.pop_front();
            chk("drain0_dout", 32'(data_out), 32'(exp_w));
        end
        pop = 1'b0;
        chk("drain0_empty", 32'(empty), 32'd1);
        chk("drain0_count", 32'(count), 32'd0);
        chk("drain0_aempty", 32'(almost_empty), 32'd1);

        // Twelve push/pop pairs, crossing the pointer wrap.
        for (int k = 0; k < 12; k++) begin
            push = 1'b1; pop = 1'b0; data_in = 10'(10'h300 + k);
            tick();
            chk("wrap_count1", 32'(count), 32'd1);
            push = 1'b0; pop = 1'b1;
            tick();
            chk("wrap_dout", 32'(data_out), 32'(10'h300 + k));
            chk("wrap_valid", 32'(valid_out), 32'd1);
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Pop while empty: rejected, flagged, data_out holds.
        tick();
        pop = 1'b0;
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_valid", 32'(valid_out), 32'd0);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_hold", 32'(data_out), 32'h30B);

        // Push+pop while empty: push accepted, pop rejected.
        push = 1'b1; pop = 1'b1; data_in = 10'h155;
        tick();
        push = 1'b0;
        chk("emptypp_count", 32'(count), 32'd1);
        chk("emptypp_valid", 32'(valid_out), 32'd0);
        tick();
        pop = 1'b0;
        chk("emptypp_dout", 32'(data_out), 32'h155);
        chk("emptypp_count0", 32'(count), 32'd0);

        // Async reset in the middle of traffic at count=5.
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = 10'(10'h011 + i);
            tick();
        end
        push = 1'b0;
        chk("pre_arst_count", 32'(count), 32'd5);
        #2 reset_L = 1'b0;
        #1;
        chk("arst_count_now", 32'(count), 32'd0);
        tick();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_unf", 32'(underflow), 32'd0);
        reset_L = 1'b1;
        tick();

        // All-zero push: stored normally, dropped silently by DROP_ZERO=1.
        push = 1'b1; data_in = 10'h000;
        tick();
        chk("zero_keep_count", 32'(count), 32'd1);
        chk("zero_drop_count", 32'(dz_count), 32'd0);
        chk("zero_drop_ovf", 32'(dz_overflow), 32'd0);
        data_in = 10'h001;
        tick();
        push = 1'b0;
        chk("zero_drop_next", 32'(dz_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_param_thresh
